ula_ctrl: RTL and testbench

//  Multi-cycle sequencer that drives the 8-bit ALU (ula): accepts a 16-bit instruction over a

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula.sv | 23 ++
 rtl/ula_regfile.sv | 30 +++
 rtl/ula_ctrl.sv | 71 +++++++
 tb/tb_ula_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared op codes, instruction layout and controller states for the ula datapath
package ula_pkg;
  localparam int ILEN = 16;
  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_ADD     = 3'b010,
    OP_ILLEGAL = 3'b011,
    OP_ANDN    = 3'b100,
    OP_ORN     = 3'b101,
    OP_SUB     = 3'b110,
    OP_GT      = 3'b111
  } op_e;
  typedef struct packed {
    logic       imm_sel;
    op_e        op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [7:0] payload;
  } instr_t;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_e;
endpackage

// File: rtl/ula.sv
// ula: purely combinational 8-bit ALU driven by ula_ctrl
module ula import ula_pkg::*; #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [2:0]    op_i,
  output logic [DW-1:0] y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_ADD:  y_o = a_i + b_i;
      OP_ANDN: y_o = a_i & ~b_i;
      OP_ORN:  y_o = a_i | ~b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_GT:   y_o = DW'(a_i > b_i);
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/ula_regfile.sv
// ula_regfile: NREGS x DW register file, two operand read ports, a debug read port, one write port
module ula_regfile #(
  parameter int NREGS = 4,
  parameter int DW    = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] ra1_i,
  input  logic [RW-1:0] ra2_i,
  input  logic [RW-1:0] dbg_addr_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  output logic [DW-1:0] dbg_data_o,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [DW-1:0] wd_i
);
  logic [DW-1:0] mem_q [NREGS];
  assign rd1_o      = mem_q[ra1_i];
  assign rd2_o      = mem_q[ra2_i];
  assign dbg_data_o = mem_q[dbg_addr_i];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: multi-cycle sequencer feeding the ula from a small register file and writing results back
module ula_ctrl import ula_pkg::*; #(
  parameter int NREGS = 4,
  parameter int DW    = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [ILEN-1:0] instr,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [2:0]      alu_op,
  input  logic [DW-1:0]   alu_result,
  output logic            done,
  output logic            err,
  input  logic [RW-1:0]   dbg_addr,
  output logic [DW-1:0]   dbg_data
);
  state_e        state_q, state_d;
  instr_t        ir_q;
  logic [DW-1:0] a_q, b_q, res_q, rd1, rd2;
  logic [2:0]    op_q;
  logic          legal;
  assign legal = ir_q.op != OP_ILLEGAL;
  always_comb begin
    state_d = (state_q == IDLE) ? (instr_valid ? READ : IDLE) :
              (state_q == READ) ? (legal ? EXEC : ERR) :
              (state_q == EXEC) ? WB : IDLE;
  end
  // Operands only load for legal ops so an illegal instruction leaves the ALU inputs untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) ir_q <= instr;
      if (state_q == READ && legal) begin
        a_q  <= rd1;
        b_q  <= ir_q.imm_sel ? DW'(ir_q.payload) : rd2;
        op_q <= ir_q.op;
      end
      if (state_q == EXEC) res_q <= alu_result;
    end
  end
  ula_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .ra1_i      (ir_q.rs1),
    .ra2_i      (ir_q.payload[7:6]),
    .dbg_addr_i (dbg_addr),
    .rd1_o      (rd1),
    .rd2_o      (rd2),
    .dbg_data_o (dbg_data),
    .we_i       (state_q == WB),
    .wa_i       (ir_q.rd),
    .wd_i       (res_q)
  );
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign done        = state_q == WB || state_q == ERR;
  assign err         = state_q == ERR;
  assign instr_ready = state_q == IDLE && !rst;
endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: directed checks of ula_ctrl driving a ula, with cycle-exact done/ready timing
module tb_ula_ctrl;
  import ula_pkg::*;
  logic        clk = 0, rst = 1, instr_valid = 0;
  logic [15:0] instr = '0;
  logic        instr_ready, done, err;
  logic [7:0]  alu_a, alu_b, alu_result, dbg_data;
  logic [2:0]  alu_op;
  logic [1:0]  dbg_addr = '0;
  int          n_chk = 0, n_fail = 0, acc = 0, dn = 0;
  bit          mon = 0;

  ula_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  ula u_alu (.a_i(alu_a), .b_i(alu_b), .op_i(alu_op), .y_o(alu_result));

  always #5 clk = ~clk;
  always @(negedge clk) if (mon) begin
    if (instr_valid && instr_ready) acc++;
    if (done) dn++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] enc(input logic imm, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] rs1,
                                      input logic [7:0] p);
    return {imm, op, rd, rs1, p};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] r, input logic [7:0] e, input string tag);
    dbg_addr = r;
    #1 chk(tag, 16'(dbg_data), 16'(e));
  endtask

  // Called at posedge+2 with the controller idle; returns at posedge+2 after ready is back
  task automatic send(input logic [15:0] ins, input bit ill, input string tag);
    instr = ins;
    instr_valid = 1;
    @(posedge clk); #2 instr_valid = 0;
    @(negedge clk); chk({tag, "/n1"}, 16'({done, err, instr_ready}), 16'(3'b000));
    if (!ill) begin
      @(negedge clk); chk({tag, "/n2"}, 16'({done, err, instr_ready}), 16'(3'b000));
    end
    @(negedge clk); chk({tag, "/done"}, 16'({done, err, instr_ready}), ill ? 16'(3'b110) : 16'(3'b100));
    @(negedge clk); chk({tag, "/ready"}, 16'({done, err, instr_ready}), 16'(3'b001));
    @(posedge clk); #2;
  endtask

  initial begin
    // reset
    #12;
    chk("rst_outs", 16'({done, err, alu_op}), 16'(0));
    chk("rst_ab", {alu_a, alu_b}, 16'(0));
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("rel_ready", 16'({done, err, instr_ready}), 16'(3'b001));
    for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00, "rst_reg");
    @(posedge clk); #2;
    // immediates
    send(enc(1, OP_ADD, 0, 0, 8'h05), 0, "addi_r0");
    chk_reg(0, 8'h05, "r0_05");
    send(enc(1, OP_ADD, 1, 1, 8'hFA), 0, "addi_r1");
    chk_reg(1, 8'hFA, "r1_fa");
    send(enc(0, OP_ADD, 2, 0, {2'd1, 6'd0}), 0, "add_r2");
    chk_reg(2, 8'hFF, "r2_ff");
    // wrap / sub
    send(enc(1, OP_ADD, 1, 1, 8'h0D), 0, "addi_wrap_r1");
    chk_reg(1, 8'h07, "r1_07");
    send(enc(0, OP_SUB, 3, 0, {2'd1, 6'd0}), 0, "sub_r3");
    chk_reg(3, 8'hFE, "r3_fe");
    chk("sub_alu_a", 16'(alu_a), 16'h05);
    chk("sub_alu_b", 16'(alu_b), 16'h07);
    chk("sub_alu_op", 16'(alu_op), 16'(3'b110));
    send(enc(1, OP_ADD, 0, 0, 8'hFA), 0, "addi_r0_ff");
    chk_reg(0, 8'hFF, "r0_ff");
    send(enc(1, OP_ADD, 0, 0, 8'h01), 0, "addi_r0_wrap");
    chk_reg(0, 8'h00, "r0_wrap_00");
    // logic / GT
    send(enc(1, OP_OR, 0, 0, 8'hF0), 0, "ori_r0");
    send(enc(1, OP_AND, 1, 1, 8'h00), 0, "andi_r1");
    send(enc(1, OP_OR, 1, 1, 8'h3C), 0, "ori_r1");
    chk_reg(0, 8'hF0, "r0_f0");
    chk_reg(1, 8'h3C, "r1_3c");
    send(enc(0, OP_ANDN, 2, 0, {2'd1, 6'd0}), 0, "andn");
    chk_reg(2, 8'hC0, "andn_c0");
    send(enc(0, OP_ORN, 2, 0, {2'd1, 6'd0}), 0, "orn");
    chk_reg(2, 8'hF3, "orn_f3");
    send(enc(0, OP_GT, 2, 0, {2'd1, 6'd0}), 0, "gt_r0r1");
    chk_reg(2, 8'h01, "gt_01");
    send(enc(0, OP_GT, 3, 1, {2'd0, 6'd0}), 0, "gt_r1r0");
    chk_reg(3, 8'h00, "gt_00");
    send(enc(0, OP_ADD, 0, 0, {2'd0, 6'd0}), 0, "hazard_add");
    chk_reg(0, 8'hE0, "hazard_e0");
    // illegal op
    send(enc(1, OP_AND, 2, 2, 8'h00), 0, "andi_r2");
    send(enc(1, OP_OR, 2, 2, 8'h55), 0, "ori_r2");
    send(enc(0, OP_ILLEGAL, 2, 0, 8'h00), 1, "illegal");
    chk_reg(2, 8'h55, "ill_r2_kept");
    chk("ill_alu_op", 16'(alu_op), 16'(3'b001));
    chk("ill_alu_b", 16'(alu_b), 16'h55);
    // valid held high continuously
    acc = 0; dn = 0; mon = 1;
    instr = enc(1, OP_ADD, 3, 3, 8'h01);
    instr_valid = 1;
    repeat (8) @(posedge clk);
    #2 instr_valid = 0;
    repeat (4) @(posedge clk);
    #2 mon = 0;
    chk("held_accepts", 16'(acc), 16'd2);
    chk("held_dones", 16'(dn), 16'd2);
    chk_reg(3, 8'h02, "held_r3");
    // reset during EXEC aborts
    acc = 0; dn = 0; mon = 1;
    instr = enc(1, OP_ADD, 1, 0, 8'h33);
    instr_valid = 1;
    @(posedge clk); #2 instr_valid = 0;
    @(posedge clk); #3 rst = 1;
    #1;
    chk("abort_de", 16'({done, err}), 16'(0));
    chk("abort_alu_a", 16'(alu_a), 16'(0));
    chk("abort_alu_op", 16'(alu_op), 16'(0));
    @(posedge clk); #2 rst = 0;
    repeat (4) @(posedge clk);
    #2 mon = 0;
    chk("abort_no_done", 16'(dn), 16'd0);
    chk("abort_ready", 16'(instr_ready), 16'd1);
    chk_reg(1, 8'h00, "abort_r1");
    chk_reg(0, 8'h00, "abort_r0");
    send(enc(1, OP_ADD, 1, 0, 8'h11), 0, "post_abort");
    chk_reg(1, 8'h11, "post_abort_r1");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
